// File: rtl/fetch_queue.sv
// Instruction fetch unit with back-to-back prefetch, a QUEUE_DEPTH-entry
// instruction/PC FIFO towards the decoder, and a redirect path that lets an
// in-flight memory response complete before it is thrown away.
module fetch_queue #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  output logic [ADDR_WIDTH-1:0]          mem_addr,
  output logic                           mem_we,
  output logic                           mem_req_valid,
  input  logic [DATA_WIDTH-1:0]          mem_rdata,
  input  logic                           mem_data_valid,
  input  logic                           redirect_valid,
  input  logic [ADDR_WIDTH-1:0]          redirect_pc,
  input  logic                           decoder_stall,
  output logic                           instr_valid,
  output logic [DATA_WIDTH-1:0]          instr,
  output logic [ADDR_WIDTH-1:0]          instr_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic                   req_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0]  data_mem [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem   [QUEUE_DEPTH];
  logic                   push_c, pop_c;
  logic [ADDR_WIDTH-1:0]  target_pc_c;
  logic                   has_room_c;
  logic                   unused_pc_lsb;

  // Redirect targets are forced to word alignment; the low bits are dropped.
  assign target_pc_c   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc[1:0];

  // Queue head is read straight out of storage for zero-cycle visibility.
  assign instr_valid   = (count_q != '0);
  assign instr         = data_mem[rd_ptr_q];
  assign instr_pc      = pc_mem[rd_ptr_q];
  assign queue_count   = count_q;
  assign mem_addr      = mem_addr_q;
  assign mem_req_valid = req_q;
  assign mem_we        = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state, fetch address and occupancy; a new request is only issued
  // when a slot is free for its response once this cycle's push/pop settle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    pop_c      = instr_valid & ~decoder_stall;
    push_c     = (state_q == S_REQ) & mem_data_valid & ~redirect_valid;
    if (redirect_valid) count_d = '0;
    else                count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    has_room_c = (count_d < CNT_W'(QUEUE_DEPTH));

    unique case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_c;
          mem_addr_d = target_pc_c;
          state_d    = S_REQ;
        end else if (has_room_c) begin
          mem_addr_d = fetch_pc_q;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_c;
          if (mem_data_valid) begin
            mem_addr_d = target_pc_c;
            state_d    = S_REQ;
          end else begin
            state_d    = S_DROP;
          end
        end else if (mem_data_valid) begin
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          if (has_room_c) begin
            mem_addr_d = fetch_pc_q + ADDR_WIDTH'(4);
            state_d    = S_REQ;
          end else begin
            state_d    = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_c;
          if (mem_data_valid) begin
            mem_addr_d = target_pc_c;
            state_d    = S_REQ;
          end
        end else if (mem_data_valid) begin
          mem_addr_d = fetch_pc_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch PC, memory request registers and occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= RESET_PC;
      req_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= (state_d != S_IDLE);
      count_q    <= count_d;
    end
  end

  // FIFO storage; a flush rewinds the tail onto the head so the head slot
  // keeps showing the last value while the queue is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      data_mem <= '{default: '0};
      pc_mem   <= '{default: '0};
    end else if (redirect_valid) begin
      wr_ptr_q <= rd_ptr_q;
    end else begin
      if (push_c) begin
        data_mem[wr_ptr_q] <= mem_rdata;
        pc_mem[wr_ptr_q]   <= fetch_pc_q;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a hand-driven memory handshake.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic        mem_req_valid;
  logic [31:0] mem_rdata;
  logic        mem_data_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        decoder_stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  queue_count;

  int vectors;
  int miscompares;

  fetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_req_valid (mem_req_valid),
    .mem_rdata     (mem_rdata),
    .mem_data_valid(mem_data_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .decoder_stall (decoder_stall),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .queue_count   (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'h0000_0013 | (32'(i) << 8);
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    mem_data_valid = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    decoder_stall  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b expected 0", mem_req_valid); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h expected 00000000", mem_addr); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ivalid: got %b expected 0", instr_valid); end
    vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL reset_ipc: got %h expected 00000000", instr_pc); end
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", queue_count); end
    vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", mem_we); end
  endtask

  // Memory answers 2 cycles after each request, decoder never stalls.
  task automatic test_stream();
    do_reset();
    step();
    for (int i = 0; i < 4; i++) begin
      vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL stream_req[%0d]: got %b expected 1", i, mem_req_valid); end
      vectors++; if (mem_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, mem_addr, 32'(4 * i)); end
      step();
      mem_rdata      = word(i);
      mem_data_valid = 1'b1;
      step();
      mem_data_valid = 1'b0;
      vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL stream_ivalid[%0d]: got %b expected 1", i, instr_valid); end
      vectors++; if (instr_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL stream_ipc[%0d]: got %h expected %h", i, instr_pc, 32'(4 * i)); end
      vectors++; if (instr !== word(i)) begin miscompares++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, instr, word(i)); end
      vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, queue_count); end
    end
  endtask

  // Fill under stall, release, then push and pop together at count 3.
  task automatic test_stall_full();
    do_reset();
    decoder_stall = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      mem_rdata      = word(i);
      mem_data_valid = 1'b1;
      step();
      mem_data_valid = 1'b0;
    end
    step();
    vectors++; if (queue_count !== 3'd4) begin miscompares++; $display("FAIL full_count: got %0d expected 4", queue_count); end
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL full_req: got %b expected 0", mem_req_valid); end
    vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL full_head_pc: got %h expected 00000000", instr_pc); end
    vectors++; if (instr !== word(0)) begin miscompares++; $display("FAIL full_head: got %h expected %h", instr, word(0)); end

    decoder_stall = 1'b0;
    step();
    vectors++; if (queue_count !== 3'd3) begin miscompares++; $display("FAIL release_count: got %0d expected 3", queue_count); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL release_req: got %b expected 1", mem_req_valid); end
    vectors++; if (mem_addr !== 32'h10) begin miscompares++; $display("FAIL release_addr: got %h expected 00000010", mem_addr); end
    vectors++; if (instr_pc !== 32'h4) begin miscompares++; $display("FAIL release_head: got %h expected 00000004", instr_pc); end

    mem_rdata      = word(4);
    mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (queue_count !== 3'd3) begin miscompares++; $display("FAIL pushpop_count: got %0d expected 3", queue_count); end
    vectors++; if (mem_addr !== 32'h14) begin miscompares++; $display("FAIL pushpop_addr: got %h expected 00000014", mem_addr); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL pushpop_req: got %b expected 1", mem_req_valid); end
    for (int k = 2; k <= 4; k++) begin
      vectors++; if (instr_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL drain_pc[%0d]: got %h expected %h", k, instr_pc, 32'(4 * k)); end
      vectors++; if (instr !== word(k)) begin miscompares++; $display("FAIL drain_instr[%0d]: got %h expected %h", k, instr, word(k)); end
      vectors++; if (queue_count !== 3'(5 - k)) begin miscompares++; $display("FAIL drain_count[%0d]: got %0d expected %0d", k, queue_count, 5 - k); end
      step();
    end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty: got %b expected 0", instr_valid); end
  endtask

  // Redirect while a request is pending: the stale response is swallowed.
  task automatic test_redirect_drop();
    do_reset();
    step();
    mem_rdata = word(0); mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    step();
    mem_rdata = word(1); mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (mem_addr !== 32'h8) begin miscompares++; $display("FAIL redir_pre_addr: got %h expected 00000008", mem_addr); end
    decoder_stall  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    step();
    redirect_valid = 1'b0;
    decoder_stall  = 1'b0;
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL redir_count: got %0d expected 0", queue_count); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL redir_req: got %b expected 1", mem_req_valid); end
    vectors++; if (mem_addr !== 32'h8) begin miscompares++; $display("FAIL redir_hold_addr: got %h expected 00000008", mem_addr); end
    step();
    vectors++; if (mem_addr !== 32'h8) begin miscompares++; $display("FAIL drop_hold_addr: got %h expected 00000008", mem_addr); end
    mem_rdata = 32'hBAD0_0BAD; mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_ivalid: got %b expected 0", instr_valid); end
    vectors++; if (mem_addr !== 32'h100) begin miscompares++; $display("FAIL drop_new_addr: got %h expected 00000100", mem_addr); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL drop_new_req: got %b expected 1", mem_req_valid); end
    step();
    mem_rdata = word(9); mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (instr_pc !== 32'h100) begin miscompares++; $display("FAIL target_pc: got %h expected 00000100", instr_pc); end
    vectors++; if (instr !== word(9)) begin miscompares++; $display("FAIL target_instr: got %h expected %h", instr, word(9)); end
    vectors++; if (queue_count !== 3'd1) begin miscompares++; $display("FAIL target_count: got %0d expected 1", queue_count); end
  endtask

  // Redirect coinciding with a response: no push, request goes to target.
  task automatic test_redirect_with_data();
    do_reset();
    step();
    mem_rdata = 32'hDEAD_BEEF; mem_data_valid = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    mem_data_valid = 1'b0; redirect_valid = 1'b0;
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL rwd_count: got %0d expected 0", queue_count); end
    vectors++; if (mem_addr !== 32'h200) begin miscompares++; $display("FAIL rwd_addr: got %h expected 00000200", mem_addr); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rwd_req: got %b expected 1", mem_req_valid); end
    step();
    mem_rdata = word(7); mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (instr_pc !== 32'h200) begin miscompares++; $display("FAIL rwd_ipc: got %h expected 00000200", instr_pc); end
    vectors++; if (instr !== word(7)) begin miscompares++; $display("FAIL rwd_instr: got %h expected %h", instr, word(7)); end
    vectors++; if (mem_addr !== 32'h204) begin miscompares++; $display("FAIL rwd_next_addr: got %h expected 00000204", mem_addr); end
    step();
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL rwd_no_dup: got %0d expected 0", queue_count); end
  endtask

  // Reset with a request outstanding; the late response must be ignored.
  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rmf_pre_req: got %b expected 1", mem_req_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vectors++; if (mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_reset_req: got %b expected 0", mem_req_valid); end
    mem_rdata = 32'hCAFE_0013; mem_data_valid = 1'b1;
    step();
    mem_data_valid = 1'b0;
    vectors++; if (queue_count !== 3'd0) begin miscompares++; $display("FAIL rmf_count: got %0d expected 0", queue_count); end
    vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_ivalid: got %b expected 0", instr_valid); end
    vectors++; if (mem_req_valid !== 1'b1) begin miscompares++; $display("FAIL rmf_req: got %b expected 1", mem_req_valid); end
    vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("FAIL rmf_addr: got %h expected 00000000", mem_addr); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect_drop();
    test_redirect_with_data();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-instruction fetch unit.
- Owns the PC and issues word fetches over the existing req_valid/data_valid memory handshake.
- Buffers fetched instructions, each with its PC, in a QUEUE_DEPTH-entry FIFO that feeds the decoder.
- Adds two capabilities the previous fetch lacked: back-to-back prefetch, and a redirect (flush) path that safely discards an in-flight response.

Parameters:
- ADDR_WIDTH, 32, width of the PC and of the memory address.
- DATA_WIDTH, 32, instruction word width.
- QUEUE_DEPTH, 4, number of FIFO entries; a power of two, at least 2.
- RESET_PC, 0, first fetch address after reset; must be word aligned.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- mem_addr  output  ADDR_WIDTH  fetch address; stable while mem_req_valid is high.
- mem_we  output  1  memory write enable; tied to 0 (fetch is read-only).
- mem_req_valid  output  1  a fetch request is outstanding.
- mem_rdata  input  DATA_WIDTH  returned instruction word.
- mem_data_valid  input  1  one-cycle pulse; completes the outstanding request.
- redirect_valid  input  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  input  ADDR_WIDTH  new fetch target.
- decoder_stall  input  1  decoder cannot accept the head entry this cycle.
- instr_valid  output  1  the queue head is valid.
- instr  output  DATA_WIDTH  head instruction.
- instr_pc  output  ADDR_WIDTH  PC of the head instruction.
- queue_count  output  $clog2(QUEUE_DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; fetch_pc=RESET_PC; queue empty.
  - Outputs: mem_req_valid=0, mem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, queue_count=0.
  - Reset overrides every other input in the same cycle.
- Derived signals:
  - pop = instr_valid & ~decoder_stall.
  - push = accepted response, i.e. state REQ & mem_data_valid & ~redirect_valid.
  - count_next = count + push − pop.
- FIFO: head outputs are driven directly from storage, so there is zero-cycle visibility of the head. Push and pop in the same cycle are legal, including when the queue is full or when it holds 1 entry.
- The FSM has three states:
  - IDLE: no request outstanding; data returned in this state is ignored. Move to REQ when count_next < QUEUE_DEPTH, with mem_addr<=fetch_pc.
  - REQ: mem_req_valid=1, with the in-flight request reserving one slot.
    - On mem_data_valid: push {fetch_pc, mem_rdata} and set fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH).
    - If count_next < QUEUE_DEPTH, stay in REQ and present the new address next cycle (back-to-back fetch, one word per 2 cycles at minimum). Otherwise go to IDLE.
  - DROP: mem_req_valid=1 and mem_addr held at the stale address. On mem_data_valid, discard the data and go to REQ at fetch_pc (the redirect target).
- Redirect (priority over push and pop):
  - Queue cleared (count=0 next cycle); fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}.
  - From IDLE: go to REQ.
  - From REQ without data: go to DROP.
  - From REQ with data in the same cycle: discard the data and go to REQ at the target.
  - From DROP: update the target, stay in DROP (or go to REQ if data arrives that cycle).
- The memory is never cancelled: mem_addr and mem_req_valid stay stable until mem_data_valid.
- instr_valid=(count!=0). instr and instr_pc are undefined-but-stable when not valid; the implementation holds the last head value.
- A response arriving in IDLE (for example, after reset mid-fetch) is dropped silently.
- The queue never overflows: the slot reservation guarantees push only when count_next <= QUEUE_DEPTH.

Test Plan:
- Reset, then memory returning data 2 cycles after each request with 0x00000013 and decoder_stall=0 → requests at 0x0, 0x4, 0x8…; instr_valid rises 1 cycle after the first data_valid with instr_pc=0x0; PCs increase by 4.
- decoder_stall=1 held, QUEUE_DEPTH=4 → exactly 4 responses accepted, queue_count=4, mem_req_valid=0. Release the stall → a pop and a new request at 0x10 in the same cycle.
- redirect_valid with redirect_pc=0x103 while REQ is pending at 0x8 → queue_count=0 next cycle, state DROP. Returned data for 0x8 is discarded (never seen at instr); the next request goes to 0x100.
- Redirect in the same cycle as mem_data_valid → that data is not pushed; the next mem_addr is the redirect target; no duplicate entries.
- Queue full with simultaneous pop and response (count=3 with one outstanding) → count stays 3, order is preserved, and a new request is issued.
- reset asserted while REQ is outstanding, with data_valid arriving the cycle after reset → data ignored, queue_count=0, next request at RESET_PC.
